// File: rtl/ad80305_dc_cal_ctrl.sv
// DC offset calibration and correction for the AD80305 RX path.
// Averages 2^AVG_LOG2 raw I/Q samples after a settle period, then subtracts the selected correction.
module ad80305_dc_cal_ctrl #(
    parameter int AVG_LOG2    = 10,
    parameter int SETTLE_CYC  = 256,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic               i_fpga_clk_125p,
    input  logic               i_fpga_rst_125p,
    input  logic               i_cal_start,
    input  logic               i_dc_bypass,
    input  logic               i_dc_set_sw,
    input  logic signed [7:0]  i_dc_corr_idata,
    input  logic signed [7:0]  i_dc_corr_qdata,
    input  logic               i_iqdata_fp,
    input  logic signed [11:0] i_idata,
    input  logic signed [11:0] i_qdata,
    output logic               o_iqdata_fp,
    output logic signed [11:0] o_idata,
    output logic signed [11:0] o_qdata,
    output logic signed [11:0] o_aver_idata,
    output logic signed [11:0] o_aver_qdata,
    output logic               o_cal_busy,
    output logic               o_cal_done,
    output logic               o_cal_timeout
);
    localparam int AW    = 12 + AVG_LOG2;
    localparam int NSAMP = 1 << AVG_LOG2;
    localparam int CW    = $clog2(SETTLE_CYC + 1);
    localparam int SW    = AVG_LOG2 + 1;
    localparam int TW    = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {IDLE, SETTLE, ACCUM, UPDATE} state_t;

    state_t                state;
    logic [CW-1:0]         cyc_cnt;
    logic [SW-1:0]         samp_cnt;
    logic [TW-1:0]         tmo_cnt;
    logic [TW-1:0]         tmo_inc;
    logic                  timeout_hit;
    logic                  last_samp;
    logic signed [AW-1:0]  acc_i;
    logic signed [AW-1:0]  acc_q;
    logic signed [11:0]    auto_i;
    logic signed [11:0]    auto_q;
    logic signed [11:0]    corr_i;
    logic signed [11:0]    corr_q;

    assign tmo_inc     = tmo_cnt + TW'(1);
    assign timeout_hit = (tmo_inc == TW'(TIMEOUT_CYC));
    assign last_samp   = i_iqdata_fp && (samp_cnt == SW'(NSAMP - 1));
    assign o_cal_busy  = (state != IDLE);

    always_ff @(posedge i_fpga_clk_125p or negedge i_fpga_rst_125p) begin
        if (!i_fpga_rst_125p) begin
            state         <= IDLE;
            cyc_cnt       <= '0;
            samp_cnt      <= '0;
            tmo_cnt       <= '0;
            acc_i         <= '0;
            acc_q         <= '0;
            auto_i        <= '0;
            auto_q        <= '0;
            o_aver_idata  <= '0;
            o_aver_qdata  <= '0;
            o_cal_done    <= 1'b0;
            o_cal_timeout <= 1'b0;
        end else begin
            o_cal_done    <= 1'b0;
            o_cal_timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_cal_start) begin
                        state    <= SETTLE;
                        cyc_cnt  <= '0;
                        samp_cnt <= '0;
                        tmo_cnt  <= '0;
                    end
                end
                SETTLE: begin
                    tmo_cnt <= tmo_inc;
                    cyc_cnt <= cyc_cnt + CW'(1);
                    if (timeout_hit) begin
                        state         <= IDLE;
                        o_cal_timeout <= 1'b1;
                    end else if (cyc_cnt == CW'(SETTLE_CYC - 1)) begin
                        state <= ACCUM;
                        acc_i <= '0;
                        acc_q <= '0;
                    end
                end
                ACCUM: begin
                    tmo_cnt <= tmo_inc;
                    if (i_iqdata_fp) begin
                        acc_i    <= acc_i + {{AVG_LOG2{i_idata[11]}}, i_idata};
                        acc_q    <= acc_q + {{AVG_LOG2{i_qdata[11]}}, i_qdata};
                        samp_cnt <= samp_cnt + SW'(1);
                    end
                    // Final sample beats a simultaneous timeout.
                    if (last_samp) begin
                        state <= UPDATE;
                    end else if (timeout_hit) begin
                        state         <= IDLE;
                        o_cal_timeout <= 1'b1;
                    end
                end
                UPDATE: begin
                    // Top 12 bits of the accumulator == arithmetic shift by AVG_LOG2 (floor).
                    o_aver_idata <= acc_i[AVG_LOG2 +: 12];
                    o_aver_qdata <= acc_q[AVG_LOG2 +: 12];
                    auto_i       <= acc_i[AVG_LOG2 +: 12];
                    auto_q       <= acc_q[AVG_LOG2 +: 12];
                    o_cal_done   <= 1'b1;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        corr_i = '0;
        corr_q = '0;
        if (!i_dc_bypass) begin
            if (i_dc_set_sw) begin
                corr_i = {{4{i_dc_corr_idata[7]}}, i_dc_corr_idata};
                corr_q = {{4{i_dc_corr_qdata[7]}}, i_dc_corr_qdata};
            end else begin
                corr_i = auto_i;
                corr_q = auto_q;
            end
        end
    end

    function automatic logic signed [11:0] sat_sub(input logic signed [11:0] s,
                                                   input logic signed [11:0] c);
        logic signed [12:0] d;
        d = {s[11], s} - {c[11], c};
        if (d > 13'sd2047)
            return 12'sh7FF;
        else if (d < -13'sd2048)
            return 12'sh800;
        else
            return d[11:0];
    endfunction

    always_ff @(posedge i_fpga_clk_125p or negedge i_fpga_rst_125p) begin
        if (!i_fpga_rst_125p) begin
            o_iqdata_fp <= 1'b0;
            o_idata     <= '0;
            o_qdata     <= '0;
        end else begin
            o_iqdata_fp <= i_iqdata_fp;
            if (i_iqdata_fp) begin
                o_idata <= sat_sub(i_idata, corr_i);
                o_qdata <= sat_sub(i_qdata, corr_q);
            end
        end
    end
endmodule

// File: tb/tb_ad80305_dc_cal_ctrl.sv
// Directed bench for ad80305_dc_cal_ctrl with short calibration parameters.
// Expected values are hand-computed constants.
module tb_ad80305_dc_cal_ctrl;
    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               start = 1'b0;
    logic               bypass = 1'b0;
    logic               set_sw = 1'b0;
    logic signed [7:0]  ci = '0;
    logic signed [7:0]  cq = '0;
    logic               valid = 1'b0;
    logic signed [11:0] idat = '0;
    logic signed [11:0] qdat = '0;
    logic               o_fp;
    logic signed [11:0] o_i;
    logic signed [11:0] o_q;
    logic signed [11:0] av_i;
    logic signed [11:0] av_q;
    logic               busy;
    logic               done;
    logic               tmo;

    int  errors = 0;
    int  checks = 0;
    bit  alt_mode = 1'b0;
    int  n;
    int  n0;
    int  pulses;
    bit  got_done;
    bit  got_tmo;

    always #4 clk = ~clk;

    ad80305_dc_cal_ctrl #(.AVG_LOG2(4), .SETTLE_CYC(8), .TIMEOUT_CYC(100)) dut (
        .i_fpga_clk_125p(clk),
        .i_fpga_rst_125p(rst_n),
        .i_cal_start(start),
        .i_dc_bypass(bypass),
        .i_dc_set_sw(set_sw),
        .i_dc_corr_idata(ci),
        .i_dc_corr_qdata(cq),
        .i_iqdata_fp(valid),
        .i_idata(idat),
        .i_qdata(qdat),
        .o_iqdata_fp(o_fp),
        .o_idata(o_i),
        .o_qdata(o_q),
        .o_aver_idata(av_i),
        .o_aver_qdata(av_q),
        .o_cal_busy(busy),
        .o_cal_done(done),
        .o_cal_timeout(tmo)
    );

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (alt_mode) idat = (idat == -12'sd3) ? -12'sd2 : -12'sd3;
    endtask

    // Waits (bounded) for done or timeout; n = ticks taken.
    task automatic wait_evt(input int limit, output int cnt, output bit d, output bit t);
        cnt = 0; d = 1'b0; t = 1'b0;
        while (cnt < limit && !d && !t) begin
            tick();
            cnt++;
            d = done;
            t = tmo;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        // Reset state
        tick(); tick();
        check("rst_o_fp", int'(o_fp), 0);
        check("rst_o_i", int'(o_i), 0);
        check("rst_aver_i", int'(av_i), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done_tmo", int'(done) + int'(tmo), 0);
        rst_n = 1'b1;

        // Constant samples; start on the first edge after reset
        valid = 1'b1; idat = 12'sd100; qdat = -12'sd50;
        pulse_start();
        check("const_busy", int'(busy), 1);
        wait_evt(60, n, got_done, got_tmo);
        check("const_done_lat", n, 25);
        check("const_done", int'(got_done), 1);
        check("const_aver_i", int'(av_i), 100);
        check("const_aver_q", int'(av_q), -50);
        tick();
        check("const_corr_i", int'(o_i), 0);
        check("const_corr_q", int'(o_q), 0);
        check("const_idle", int'(busy), 0);

        // Bypass
        bypass = 1'b1;
        tick();
        check("bypass_i", int'(o_i), 100);
        check("bypass_q", int'(o_q), -50);
        bypass = 1'b0;

        // Manual correction and saturation
        set_sw = 1'b1; ci = 8'sd100; cq = -8'sd5; idat = -12'sd2000;
        tick();
        check("man_sat_lo", int'(o_i), -2048);
        check("man_q", int'(o_q), -45);
        ci = -8'sd100; idat = 12'sd2047;
        tick();
        check("man_sat_hi", int'(o_i), 2047);
        ci = 8'sd100; idat = 12'sd500;
        tick();
        check("man_plain", int'(o_i), 400);
        valid = 1'b0; idat = 12'sd7;
        tick();
        check("hold_i", int'(o_i), 400);
        check("hold_fp", int'(o_fp), 0);
        set_sw = 1'b0;

        // Timeout with no valid samples
        pulse_start();
        wait_evt(150, n, got_done, got_tmo);
        check("tmo_cycles", n, 100);
        check("tmo_pulse", int'(got_tmo), 1);
        check("tmo_no_done", int'(got_done), 0);
        check("tmo_idle", int'(busy), 0);
        pulses = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            pulses += int'(tmo);
        end
        check("tmo_once", pulses, 0);
        check("tmo_aver_i", int'(av_i), 100);
        check("tmo_aver_q", int'(av_q), -50);
        valid = 1'b1; idat = 12'sd100; qdat = -12'sd50;
        tick();
        check("tmo_auto_kept", int'(o_i), 0);

        // Negative averaging: -3/-2 alternating, Q constant -1
        idat = -12'sd3; qdat = -12'sd1; alt_mode = 1'b1;
        pulse_start();
        wait_evt(60, n, got_done, got_tmo);
        check("neg_done_lat", n, 25);
        check("neg_aver_i", int'(av_i), -3);
        check("neg_aver_q", int'(av_q), -1);
        alt_mode = 1'b0;

        // Second start while busy must not disturb the cycle count
        idat = 12'sd7; qdat = 12'sd0;
        pulse_start();
        for (int k = 0; k < 12; k++) tick();
        pulse_start();
        n0 = 13;
        wait_evt(60, n, got_done, got_tmo);
        check("busy_start_lat", n0 + n, 25);
        check("busy_start_aver", int'(av_i), 7);

        // Reset in ACCUM
        pulse_start();
        for (int k = 0; k < 12; k++) tick();
        check("pre_rst_busy", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        check("arst_o_i", int'(o_i), 0);
        check("arst_o_fp", int'(o_fp), 0);
        check("arst_aver_i", int'(av_i), 0);
        check("arst_busy", int'(busy), 0);
        #2;
        rst_n = 1'b1;
        pulses = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            pulses += int'(done) + int'(busy);
        end
        check("arst_no_done", pulses, 0);
        check("arst_auto_cleared", int'(o_i), 7);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
